// File: rtl/can_err_pkg.sv
// Shared definitions for the CAN fault-confinement unit.
//   - can_err_state_e : fault-confinement state encoding (matches the 2-bit state port)
//   - DEF_*           : default limits used as parameter defaults by the top
//   - STF/EOF/CRC/FRM : bit positions of the error sources within err_n / err_src
package can_err_pkg;

  typedef enum logic [1:0] {
    ERR_ACTIVE  = 2'd0,
    ERR_PASSIVE = 2'd1,
    BUS_OFF     = 2'd2
  } can_err_state_e;

  localparam int unsigned DEF_N_SRC         = 4;
  localparam int unsigned DEF_CNT_W         = 9;
  localparam int unsigned DEF_WARN_LIMIT    = 96;
  localparam int unsigned DEF_PASSIVE_LIMIT = 128;
  localparam int unsigned DEF_BUSOFF_LIMIT  = 256;
  localparam int unsigned DEF_FLAG_LEN      = 6;
  localparam int unsigned DEF_RECOVERY_SEQS = 128;

  // Length of one bus-idle run counted during bus-off recovery.
  localparam int unsigned RECESSIVE_RUN = 11;

  // Error source indices.
  localparam int unsigned STF = 0;
  localparam int unsigned EOF = 1;
  localparam int unsigned CRC = 2;
  localparam int unsigned FRM = 3;

endpackage

// File: rtl/can_err_counter.sv
// Saturating CAN error counter (used for both TEC and REC).
//   clk, reset (async, active-low)
//   inc : add INC, saturating at SAT (takes priority over dec)
//   dec : decrement towards 0; with REC_RULES a value >= PASSIVE_LIMIT
//         drops straight to PASSIVE_LIMIT-8
//   clr : synchronous clear (highest priority)
//   cnt : registered counter value
module can_err_counter #(
  parameter int unsigned CNT_W         = 9,
  parameter int unsigned INC           = 1,
  parameter int unsigned SAT           = 256,
  parameter bit          REC_RULES     = 1'b0,
  parameter int unsigned PASSIVE_LIMIT = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W:0]   SAT_C  = (CNT_W + 1)'(SAT);
  localparam logic [CNT_W:0]   INC_C  = (CNT_W + 1)'(INC);
  localparam logic [CNT_W-1:0] PASS_C = CNT_W'(PASSIVE_LIMIT);
  localparam logic [CNT_W-1:0] DROP_C = CNT_W'(PASSIVE_LIMIT - 8);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + INC_C;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (sum > SAT_C) ? SAT_C[CNT_W-1:0] : sum[CNT_W-1:0];
    end else if (dec) begin
      if (REC_RULES && (cnt_q >= PASS_C)) begin
        cnt_d = DROP_C;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - ONE_C;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/can_error_manager.sv
// CAN fault confinement: error-flag generation, TEC/REC maintenance and the
// error-active / error-passive / bus-off state machine with bus-off recovery.
// Optional build macro: CAN_ERR_SRC_CAPTURE_EN adds the sticky err_src output.
//   clk, reset (async, active-low)
//   SP       : sample-point strobe; all inputs are evaluated only when SP=1
//   err_n    : active-low error sources (STF, EOF, CRC, FRM)
//   bus_rx   : sampled bus level, 1 = recessive
//   tx_mode  : node is transmitter (errors go to TEC, else REC)
//   rx_ok    : successful reception pulse
//   tx_ok    : successful transmission pulse
//   ERROR    : any error seen at the last SP (0 while bus-off)
//   flag_tx  : error flag in progress; flag_dom gives its polarity
//   tec, rec : error counters; state : fault-confinement state; warn : warning level
//   err_src  : sticky captured sources (CAN_ERR_SRC_CAPTURE_EN only)
module can_error_manager
  import can_err_pkg::*;
#(
  parameter int unsigned N_SRC         = DEF_N_SRC,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned WARN_LIMIT    = DEF_WARN_LIMIT,
  parameter int unsigned PASSIVE_LIMIT = DEF_PASSIVE_LIMIT,
  parameter int unsigned BUSOFF_LIMIT  = DEF_BUSOFF_LIMIT,
  parameter int unsigned FLAG_LEN      = DEF_FLAG_LEN,
  parameter int unsigned RECOVERY_SEQS = DEF_RECOVERY_SEQS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SP,
  input  logic [N_SRC-1:0] err_n,
  input  logic             bus_rx,
  input  logic             tx_mode,
  input  logic             rx_ok,
  input  logic             tx_ok,
  output logic             ERROR,
  output logic             flag_tx,
  output logic             flag_dom,
  output logic [CNT_W-1:0] tec,
  output logic [CNT_W-1:0] rec,
  output logic [1:0]       state,
  output logic             warn
`ifdef CAN_ERR_SRC_CAPTURE_EN
  ,
  output logic [N_SRC-1:0] err_src
`endif
);

  localparam int unsigned FCNT_W = $clog2(FLAG_LEN + 1);
  localparam int unsigned SCNT_W = $clog2(RECOVERY_SEQS + 1);

  localparam logic [CNT_W-1:0]  WARN_C    = CNT_W'(WARN_LIMIT);
  localparam logic [CNT_W-1:0]  PASS_C    = CNT_W'(PASSIVE_LIMIT);
  localparam logic [CNT_W-1:0]  BUSOFF_C  = CNT_W'(BUSOFF_LIMIT);
  localparam logic [FCNT_W-1:0] FLAST_C   = FCNT_W'(FLAG_LEN - 1);
  localparam logic [FCNT_W-1:0] FONE_C    = FCNT_W'(1);
  localparam logic [3:0]        RLAST_C   = 4'(RECESSIVE_RUN - 1);
  localparam logic [SCNT_W-1:0] SLAST_C   = SCNT_W'(RECOVERY_SEQS - 1);

  can_err_state_e    state_q;
  logic              error_q;
  logic              pend_q;   // error accepted, flag starts at the next SP
  logic              flag_q;
  logic              dom_q;
  logic [FCNT_W-1:0] fcnt_q;   // flag SPs already sent
  logic [3:0]        run_q;    // recessive samples in the current run
  logic [SCNT_W-1:0] seq_q;    // completed recessive runs

  logic any_err, busoff, err_evt, ok_en, recover;

  assign any_err = |(~err_n);
  assign busoff  = (state_q == BUS_OFF);
  // The pending slot blocks a second event before flag_tx is visible, so an
  // error on the SP that starts the flag cannot restart it.
  assign err_evt = SP & any_err & ~pend_q & ~flag_q & ~busoff;
  assign ok_en   = SP & ~err_evt & ~busoff;
  assign recover = busoff & SP & bus_rx & (run_q == RLAST_C) & (seq_q == SLAST_C);

  can_err_counter #(
    .CNT_W        (CNT_W),
    .INC          (8),
    .SAT          (BUSOFF_LIMIT),
    .REC_RULES    (1'b0),
    .PASSIVE_LIMIT(PASSIVE_LIMIT)
  ) u_tec (
    .clk  (clk),
    .reset(reset),
    .inc  (err_evt & tx_mode),
    .dec  (ok_en & tx_ok),
    .clr  (recover),
    .cnt  (tec)
  );

  can_err_counter #(
    .CNT_W        (CNT_W),
    .INC          (1),
    .SAT          (PASSIVE_LIMIT + 8),
    .REC_RULES    (1'b1),
    .PASSIVE_LIMIT(PASSIVE_LIMIT)
  ) u_rec (
    .clk  (clk),
    .reset(reset),
    .inc  (err_evt & ~tx_mode),
    .dec  (ok_en & rx_ok),
    .clr  (recover),
    .cnt  (rec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ERR_ACTIVE;
      error_q <= 1'b0;
      pend_q  <= 1'b0;
      flag_q  <= 1'b0;
      dom_q   <= 1'b0;
      fcnt_q  <= '0;
      run_q   <= '0;
      seq_q   <= '0;
    end else begin
      if (SP) begin
        error_q <= any_err & ~busoff;
      end

      if (err_evt) begin
        pend_q <= 1'b1;
        dom_q  <= (state_q == ERR_ACTIVE);
      end else if (SP && pend_q) begin
        pend_q <= 1'b0;
        flag_q <= 1'b1;
        fcnt_q <= FONE_C;
      end else if (SP && flag_q) begin
        if (fcnt_q == FLAST_C) begin
          flag_q <= 1'b0;
        end else begin
          fcnt_q <= fcnt_q + FONE_C;
        end
      end

      // Recovery counters only run while bus-off.
      if (!busoff) begin
        run_q <= '0;
        seq_q <= '0;
      end else if (SP) begin
        if (!bus_rx) begin
          run_q <= '0;
        end else if (run_q == RLAST_C) begin
          run_q <= '0;
          seq_q <= recover ? '0 : seq_q + 1'b1;
        end else begin
          run_q <= run_q + 1'b1;
        end
      end

      // State follows the registered counters, hence one clock behind them.
      case (state_q)
        BUS_OFF: begin
          if (recover) state_q <= ERR_ACTIVE;
        end
        default: begin
          if (tec >= BUSOFF_C) begin
            state_q <= BUS_OFF;
          end else if ((tec >= PASS_C) || (rec >= PASS_C)) begin
            state_q <= ERR_PASSIVE;
          end else begin
            state_q <= ERR_ACTIVE;
          end
        end
      endcase
    end
  end

`ifdef CAN_ERR_SRC_CAPTURE_EN
  logic [N_SRC-1:0] src_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q <= '0;
    end else if (recover) begin
      src_q <= '0;
    end else if (err_evt) begin
      src_q <= src_q | ~err_n;
    end
  end

  assign err_src = src_q;
`endif

  assign ERROR    = error_q & ~busoff;
  assign flag_tx  = flag_q;
  assign flag_dom = dom_q;
  assign state    = state_q;
  assign warn     = (tec >= WARN_C) | (rec >= WARN_C);

endmodule

// File: tb/tb_can_error_manager.sv
// Self-checking bench for can_error_manager: directed scenarios plus a random
// phase, all compared against a behavioural model kept in plain integers.
module tb_can_error_manager;

  localparam int FLAG_LEN = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       SP;
  logic [3:0] err_n;
  logic       bus_rx;
  logic       tx_mode;
  logic       rx_ok;
  logic       tx_ok;
  logic       ERROR;
  logic       flag_tx;
  logic       flag_dom;
  logic [8:0] tec;
  logic [8:0] rec;
  logic [1:0] state;
  logic       warn;
`ifdef CAN_ERR_SRC_CAPTURE_EN
  logic [3:0] err_src;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  can_error_manager dut (
    .clk     (clk),
    .reset   (reset),
    .SP      (SP),
    .err_n   (err_n),
    .bus_rx  (bus_rx),
    .tx_mode (tx_mode),
    .rx_ok   (rx_ok),
    .tx_ok   (tx_ok),
    .ERROR   (ERROR),
    .flag_tx (flag_tx),
    .flag_dom(flag_dom),
    .tec     (tec),
    .rec     (rec),
    .state   (state),
    .warn    (warn)
`ifdef CAN_ERR_SRC_CAPTURE_EN
    ,
    .err_src (err_src)
`endif
  );

  // Reference model: counters and states as plain integers (0 active,
  // 1 passive, 2 bus-off), the flag as a count of remaining flag SPs.
  int       m_tec, m_rec, m_state, m_flag_left, m_run, m_seqs;
  bit       m_err, m_pend, m_dom;
  bit [3:0] m_src;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tec = 0; m_rec = 0; m_state = 0; m_flag_left = 0; m_run = 0; m_seqs = 0;
    m_err = 0; m_pend = 0; m_dom = 0; m_src = '0;
  endtask

  task automatic model_step(input bit sp, input bit [3:0] en, input bit brx, input bit txm,
                            input bit rxo, input bit txo);
    bit any, ev, recover;
    int old_tec, old_rec, old_state;
    any = (en != 4'hF);
    old_tec = m_tec; old_rec = m_rec; old_state = m_state;
    ev = sp && any && !m_pend && (m_flag_left == 0) && (old_state != 2);
    recover = 0;
    if (ev) begin
      if (txm) m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
      else     m_rec = (m_rec + 1 > 136) ? 136 : m_rec + 1;
      m_src = m_src | ~en;
    end else if (sp && old_state != 2) begin
      if (txo && m_tec > 0) m_tec = m_tec - 1;
      if (rxo) begin
        if (m_rec >= 128)   m_rec = 120;
        else if (m_rec > 0) m_rec = m_rec - 1;
      end
    end
    if (old_state == 2 && sp) begin
      if (brx) begin
        m_run++;
        if (m_run == 11) begin
          m_run = 0;
          m_seqs++;
          if (m_seqs == 128) recover = 1;
        end
      end else begin
        m_run = 0;
      end
    end
    if (sp) m_err = any && (old_state != 2);
    if (ev) begin
      m_pend = 1;
      m_dom  = (old_state == 0);
    end else if (sp && m_pend) begin
      m_pend = 0;
      m_flag_left = FLAG_LEN - 1;
    end else if (sp && m_flag_left > 0) begin
      m_flag_left--;
    end
    if (recover) begin
      m_state = 0; m_tec = 0; m_rec = 0; m_run = 0; m_seqs = 0; m_src = '0;
    end else if (old_state != 2) begin
      if (old_tec >= 256) m_state = 2;
      else if (old_tec >= 128 || old_rec >= 128) m_state = 1;
      else m_state = 0;
    end
    if (old_state != 2) begin
      m_run = 0; m_seqs = 0;
    end
  endtask

  task automatic check_outputs();
    check("ERROR", ERROR, (m_err && m_state != 2) ? 1 : 0);
    check("flag_tx", flag_tx, (m_flag_left > 0) ? 1 : 0);
    if (m_flag_left > 0) check("flag_dom", flag_dom, m_dom);
    check("tec", tec, m_tec);
    check("rec", rec, m_rec);
    check("state", state, m_state);
    check("warn", warn, (m_tec >= 96 || m_rec >= 96) ? 1 : 0);
`ifdef CAN_ERR_SRC_CAPTURE_EN
    check("err_src", err_src, m_src);
`endif
  endtask

  task automatic step(input bit sp, input bit [3:0] en, input bit brx, input bit txm,
                      input bit rxo, input bit txo);
    @(negedge clk);
    SP = sp; err_n = en; bus_rx = brx; tx_mode = txm; rx_ok = rxo; tx_ok = txo;
    @(posedge clk);
    model_step(sp, en, brx, txm, rxo, txo);
    #1;
    check_outputs();
  endtask

  task automatic idle_sp(input int n);
    for (int i = 0; i < n; i++) step(1, 4'hF, 1, 0, 0, 0);
  endtask

  task automatic spaced_err(input bit txm);
    bit [3:0] en;
    en = 4'($urandom_range(0, 14));
    step(1, en, 1, txm, 0, 0);
    idle_sp(7);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    SP = 0; err_n = 4'hF; bus_rx = 1; tx_mode = 0; rx_ok = 0; tx_ok = 0;
    #1;
    model_reset();
    check_outputs();
    check("rst_flag_dom", flag_dom, 0);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    int budget;
    reset = 0; SP = 0; err_n = 4'hF; bus_rx = 1; tx_mode = 0; rx_ok = 0; tx_ok = 0;
    model_reset();
    do_reset();

    // First RX error: rec=1, flag with dominant polarity.
    step(1, 4'b1110, 1, 0, 0, 0);
    check("tp1_error", ERROR, 1);
    check("tp1_rec", rec, 1);
    step(1, 4'hF, 1, 0, 0, 0);
    check("tp1_flag_dom", flag_dom, 1);
    idle_sp(7);

    // 16 TX errors reach error-passive.
    for (int i = 0; i < 16; i++) spaced_err(1);
    check("tp2_tec", tec, 128);
    check("tp2_state", state, 1);
    step(1, 4'b0111, 1, 1, 0, 0);
    step(1, 4'hF, 1, 0, 0, 0);
    check("tp2_flag_dom", flag_dom, 0);
    idle_sp(6);

    // 15 more TX errors reach bus-off (32 in total).
    for (int i = 0; i < 15; i++) spaced_err(1);
    check("tp3_tec", tec, 256);
    check("tp3_state", state, 2);
    step(1, 4'b0000, 1, 1, 0, 0);
    check("tp3_error_forced", ERROR, 0);

    // Recovery with occasional dominant samples restarting a run.
    budget = 0;
    while (m_state == 2 && budget < 4000) begin
      step(1, 4'($urandom_range(0, 15)), ($urandom_range(0, 99) != 0), 1, 0, 0);
      budget++;
    end
    check("tp3_recovery_timeout", (budget < 4000) ? 1 : 0, 1);
    check("tp3_state_active", state, 0);
    check("tp3_tec_clr", tec, 0);
    check("tp3_rec_clr", rec, 0);

    // rec to 130, rx_ok drops it to 120; saturation at 136.
    for (int i = 0; i < 130; i++) spaced_err(0);
    check("tp4_rec130", rec, 130);
    step(1, 4'hF, 1, 0, 1, 0);
    check("tp4_rec120", rec, 120);
    for (int i = 0; i < 20; i++) spaced_err(0);
    check("tp4_rec_sat", rec, 136);
    step(1, 4'hF, 1, 0, 1, 0);
    check("tp4_rec_drop", rec, 120);
    idle_sp(2);

    // Error and tx_ok on the same SP: error wins.
    spaced_err(1);
    step(1, 4'b1101, 1, 1, 0, 1);
    check("tp5_tec_err_wins", tec, 16);
    // Errors during the flag are ignored.
    for (int i = 0; i < 6; i++) step(1, 4'b1011, 1, 1, 0, 0);
    check("tp5_tec_during_flag", tec, 16);
    idle_sp(3);

    // Reset mid-flag.
    step(1, 4'b1110, 1, 0, 0, 0);
    idle_sp(2);
    check("tp6_flag_before_rst", flag_tx, 1);
    do_reset();
    check("tp6_flag_after_rst", flag_tx, 0);
    idle_sp(2);

`ifdef CAN_ERR_SRC_CAPTURE_EN
    step(1, 4'b1011, 1, 0, 0, 0);
    idle_sp(7);
    step(1, 4'b1110, 1, 0, 0, 0);
    check("tp7_err_src", err_src, 4'b0101);
    idle_sp(7);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit okp;
      okp = (m_state != 2);
      step($urandom_range(0, 1),
           ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
           ($urandom_range(0, 9) != 0),
           $urandom_range(0, 1),
           okp && ($urandom_range(0, 4) == 0),
           okp && ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/can_error_manager.md
# can_error_manager

Parametrised CAN fault-confinement unit that replaces the single-shot error combiner in the decoder back end. Samples N active-low error sources at each sample point, drives an error flag onto the bus, and maintains transmit/receive error counters (TEC/REC). Also runs the error-active / error-passive / bus-off state machine, including bus-off recovery. Sits between the bit-level checkers (stuff, CRC, form, EOF) and the frame controller / bus driver.

## Interface
Parameters:
- N_SRC, 4 — number of error sources.
- CNT_W, 9 — TEC/REC width; must hold BUSOFF_LIMIT.
- WARN_LIMIT, 96 — error-warning threshold.
- PASSIVE_LIMIT, 128 — error-passive threshold.
- BUSOFF_LIMIT, 256 — TEC bus-off threshold.
- FLAG_LEN, 6 — error-flag length in bits.
- RECOVERY_SEQS, 128 — bus-off recovery sequence count.

Ports:
- clk  in  1  — system clock.
- reset  in  1  — asynchronous, active-low reset.
- SP  in  1  — sample-point strobe, one clk wide.
- err_n  in  N_SRC  — error sources, active-low; index 0 = stuff, 1 = EOF, 2 = CRC, 3 = form.
- bus_rx  in  1  — sampled bus level; 1 = recessive.
- tx_mode  in  1  — node is currently the transmitter.
- rx_ok  in  1  — one-cycle pulse on a successful reception.
- tx_ok  in  1  — one-cycle pulse on a successful transmission.
- ERROR  out  1  — error detected at the last SP.
- flag_tx  out  1  — error flag in progress.
- flag_dom  out  1  — flag polarity; 1 = dominant.
- tec  out  CNT_W  — transmit error counter.
- rec  out  CNT_W  — receive error counter.
- state  out  2  — fault-confinement state.
- warn  out  1  — tec or rec ≥ WARN_LIMIT.
- err_src  out  N_SRC  — captured error sources; present only with CAN_ERR_SRC_CAPTURE_EN.

## Operation
- Inputs are evaluated only on clk edges where SP=1.
- Error event: SP=1, any err_n bit low, flag_tx=0, and state≠BUS_OFF.
- Errors that occur while flag_tx=1 are not counted and do not restart the flag.
- On an error event:
  - tx_mode=1 → tec += 8.
  - tx_mode=0 → rec += 1.
  - rec saturates at PASSIVE_LIMIT+8.
- rx_ok: rec -= 1 if 0 < rec < PASSIVE_LIMIT; rec := PASSIVE_LIMIT-8 if rec ≥ PASSIVE_LIMIT; no change when rec=0.
- tx_ok: tec -= 1 if tec > 0.
- Error event and ok pulse on the same edge: the error wins and the ok pulse is dropped.
- States (package enum): ERR_ACTIVE=0, ERR_PASSIVE=1, BUS_OFF=2.
  - ACTIVE→PASSIVE when tec or rec ≥ PASSIVE_LIMIT.
  - PASSIVE→ACTIVE when both < PASSIVE_LIMIT.
  - Any state→BUS_OFF when tec ≥ BUSOFF_LIMIT.
  - BUS_OFF→ACTIVE after RECOVERY_SEQS runs of 11 consecutive recessive SP samples; tec and rec clear to 0 on that transition.
  - A dominant sample during a run restarts that run only.
- Error flag: starts on the first SP after the error event and lasts FLAG_LEN SPs. flag_dom = 1 if the state was ERR_ACTIVE at the error edge, else 0.
- ERROR is set on each SP edge to the OR of the inverted err_n bits and held until the next SP. It is forced to 0 in BUS_OFF.

## Timing
- Reset values: all outputs 0, state=ERR_ACTIVE, recovery counters 0.
- Counters, state and ERROR are visible 1 clk after the SP edge.
- flag_tx rises 1 clk after the SP edge that follows the error event.
- flag_tx falls 1 clk after the FLAG_LEN-th flag SP.
- State is re-evaluated from the updated counters, so it lags a counter change by 1 clk.
- warn is combinational from the registered counters.
- Reset asserted mid-flag or mid-recovery: everything returns to reset values immediately; no partial flag continues.

## Configuration
- CAN_ERR_SRC_CAPTURE_EN defined:
  - err_src latches the inverted err_n at the first counted error event.
  - It is sticky; later events OR in.
  - It clears only on reset or on the BUS_OFF→ACTIVE transition.
- CAN_ERR_SRC_CAPTURE_EN undefined: the err_src port and its register are absent; all other behaviour is identical.

## Structure
- Package can_err_pkg holds:
  - the state enum;
  - default limit constants;
  - the source-index constants (STF, EOF, CRC, FRM).
- Sub-module can_err_counter (inc amount, dec, saturate/clamp rules) is instantiated twice, once for TEC and once for REC.

## Test plan
- Reset, then SP with err_n=4'b1110 and tx_mode=0 → ERROR=1, rec=1. Flag runs for 6 SPs with flag_dom=1.
- 16 TX errors at SP, spaced past the flag → tec=128, state=ERR_PASSIVE. The next flag has flag_dom=0.
- 32 TX errors → tec=256, state=BUS_OFF, ERROR held 0. Then 128×11 recessive SPs → state=ERR_ACTIVE, tec=rec=0.
- rec=130, then rx_ok → rec=120. Error and tx_ok on the same SP edge → tec+8, no decrement.
- New error while flag_tx=1 → counters unchanged and flag length still 6. Reset mid-flag → flag_tx=0 on the next clk.
- With CAN_ERR_SRC_CAPTURE_EN: errors on src 2, then src 0 → err_src=4'b0101.
